step_pulse_monitor: RTL and testbench

Receive-side counterpart of the step-pulse generator. Takes a STEP/DIR pulse train from the motor-drive path or from an external driver feedback tap, and recovers three things: signed step position, measured speed in the generator's speed units, and pulse-width fault status. It sits beside the motor drivers in the processor subsystem and exposes results as registers for the CPU and for closed-loop checks against the commanded speed.

---
 rtl/step_pulse_monitor.sv | 223 ++++++++++++++++++++++
 tb/tb_step_pulse_monitor.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/step_pulse_monitor.sv
// STEP/DIR receive monitor: recovers signed position, speed (SCALE / period) and pulse-width faults.
// Optional glitch filter on the synchronized STEP line: define STEP_GLITCH_FILTER_EN (FILTER_LEN >= 2).
//
// state   | meaning
// P_IDLE  | no reference edge yet (after reset or stall); next rise starts a period
// P_MEAS  | counting cycles since the last rise; each rise closes a period
// D_IDLE  | divider idle
// D_RUN   | 32 restoring-divide iterations of SCALE / period
// D_DONE  | quotient ready; publish speed and strobe speed_valid
module step_pulse_monitor #(
    parameter int unsigned SCALE      = 100000000,
    parameter int unsigned TIMEOUT    = 200000000,
    parameter int unsigned MIN_WIDTH  = 2,
    parameter int unsigned FILTER_LEN = 4
) (
    input  logic        clock_in,
    input  logic        resetn,
    input  logic        step_in,
    input  logic        dir_in,
    input  logic        clear,
    output logic [31:0] position,
    output logic [31:0] speed,
    output logic        speed_valid,
    output logic [27:0] pulse_width,
    output logic        stalled,
    output logic        width_err
);

    typedef enum logic {P_IDLE, P_MEAS} p_state_t;
    typedef enum logic [1:0] {D_IDLE, D_RUN, D_DONE} d_state_t;

    if (FILTER_LEN < 2) begin : g_filter_len_check
        $error("FILTER_LEN must be at least 2");
    end

    logic step_sync1, step_sync2, dir_sync1, dir_sync2;
    logic s, s_prev, dir_s, rise, fall;

    always_ff @(posedge clock_in or negedge resetn) begin
        if (!resetn) begin
            step_sync1 <= 1'b0;
            step_sync2 <= 1'b0;
            dir_sync1  <= 1'b0;
            dir_sync2  <= 1'b0;
        end else begin
            step_sync1 <= step_in;
            step_sync2 <= step_sync1;
            dir_sync1  <= dir_in;
            dir_sync2  <= dir_sync1;
        end
    end

`ifdef STEP_GLITCH_FILTER_EN
    localparam int FCW = $clog2(FILTER_LEN + 1);
    logic [FCW-1:0]        filt_cnt;
    logic                  step_filt;
    logic [FILTER_LEN-1:0] dir_dly;

    // dir is delayed by the same FILTER_LEN so it stays aligned with the filtered edge
    always_ff @(posedge clock_in or negedge resetn) begin
        if (!resetn) begin
            filt_cnt  <= '0;
            step_filt <= 1'b0;
            dir_dly   <= '0;
        end else begin
            dir_dly <= {dir_dly[FILTER_LEN-2:0], dir_sync2};
            if (step_sync2 == step_filt) begin
                filt_cnt <= '0;
            end else if (filt_cnt == FCW'(FILTER_LEN - 1)) begin
                step_filt <= step_sync2;
                filt_cnt  <= '0;
            end else begin
                filt_cnt <= filt_cnt + 1'b1;
            end
        end
    end

    assign s     = step_filt;
    assign dir_s = dir_dly[FILTER_LEN-1];
`else
    assign s     = step_sync2;
    assign dir_s = dir_sync2;
`endif

    assign rise = s & ~s_prev;
    assign fall = ~s & s_prev;

    logic [27:0] width_cnt;

    always_ff @(posedge clock_in or negedge resetn) begin
        if (!resetn) begin
            s_prev      <= 1'b0;
            position    <= '0;
            width_cnt   <= '0;
            pulse_width <= '0;
            width_err   <= 1'b0;
        end else begin
            s_prev <= s;
            if (clear)
                position <= '0;
            else if (rise)
                position <= position + (dir_s ? 32'd1 : 32'hFFFF_FFFF);

            if (rise)
                width_cnt <= 28'd1;
            else if (s && width_cnt != '1)
                width_cnt <= width_cnt + 28'd1;

            if (fall)
                pulse_width <= width_cnt;
            if (clear)
                width_err <= 1'b0;
            else if (fall && width_cnt < 28'(MIN_WIDTH))
                width_err <= 1'b1;
        end
    end

    p_state_t    p_state, p_next;
    logic [31:0] p_cnt, p_cnt_next;
    logic        handoff, timeout;

    always_ff @(posedge clock_in or negedge resetn) begin
        if (!resetn) begin
            p_state <= P_IDLE;
            p_cnt   <= '0;
        end else begin
            p_state <= p_next;
            p_cnt   <= p_cnt_next;
        end
    end

    // A rise coinciding with the timeout restarts measurement as a first edge (no hand-off)
    always_comb begin
        p_next     = p_state;
        p_cnt_next = p_cnt;
        handoff    = 1'b0;
        timeout    = 1'b0;
        case (p_state)
            P_IDLE: begin
                if (rise) begin
                    p_cnt_next = '0;
                    p_next     = P_MEAS;
                end
            end
            P_MEAS: begin
                if (p_cnt >= 32'(TIMEOUT)) begin
                    timeout    = 1'b1;
                    p_cnt_next = '0;
                    p_next     = rise ? P_MEAS : P_IDLE;
                end else if (rise) begin
                    handoff    = 1'b1;
                    p_cnt_next = '0;
                end else if (p_cnt != 32'hFFFF_FFFF) begin
                    p_cnt_next = p_cnt + 32'd1;
                end
            end
            default: p_next = P_IDLE;
        endcase
    end

    d_state_t    d_state, d_next;
    logic [31:0] div_rem, div_quo, div_den;
    logic [4:0]  div_cnt;
    logic [32:0] rem_shift;

    assign rem_shift = {div_rem, div_quo[31]};

    always_comb begin
        d_next = d_state;
        if (timeout)
            d_next = D_IDLE;
        else if (handoff)
            d_next = D_RUN;
        else begin
            case (d_state)
                D_RUN:   if (div_cnt == 5'd31) d_next = D_DONE;
                D_DONE:  d_next = D_IDLE;
                default: d_next = D_IDLE;
            endcase
        end
    end

    always_ff @(posedge clock_in or negedge resetn) begin
        if (!resetn) begin
            d_state     <= D_IDLE;
            div_rem     <= '0;
            div_quo     <= '0;
            div_den     <= '0;
            div_cnt     <= '0;
            speed       <= '0;
            speed_valid <= 1'b0;
            stalled     <= 1'b1;
        end else begin
            d_state     <= d_next;
            speed_valid <= 1'b0;
            if (handoff) begin
                div_rem <= '0;
                div_quo <= 32'(SCALE);
                div_den <= p_cnt + 32'd1;
                div_cnt <= '0;
            end else if (d_state == D_RUN) begin
                div_cnt <= div_cnt + 5'd1;
                if (rem_shift >= {1'b0, div_den}) begin
                    div_rem <= 32'(rem_shift - {1'b0, div_den});
                    div_quo <= {div_quo[30:0], 1'b1};
                end else begin
                    div_rem <= rem_shift[31:0];
                    div_quo <= {div_quo[30:0], 1'b0};
                end
            end

            if (timeout) begin
                speed   <= '0;
                stalled <= 1'b1;
            end else if (d_state == D_DONE && !handoff) begin
                speed       <= div_quo;
                speed_valid <= 1'b1;
                stalled     <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_step_pulse_monitor.sv
// Bench for step_pulse_monitor: scripted and randomized STEP/DIR trains vs. an event-level model.
module tb_step_pulse_monitor;
    localparam int SCALE     = 100000;
    localparam int TIMEOUT   = 5000;
    localparam int MIN_WIDTH = 2;
    // drive-to-strobe: two synchronizer edges plus 34 cycles from the detected rise
    localparam int LAT       = 36;

    logic        clock_in = 1'b0;
    logic        resetn   = 1'b0;
    logic        step_in  = 1'b0;
    logic        dir_in   = 1'b0;
    logic        clear    = 1'b0;
    logic [31:0] position, speed;
    logic        speed_valid, stalled, width_err;
    logic [27:0] pulse_width;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    typedef struct {
        int          c;
        logic [31:0] v;
    } ev_t;

    ev_t ev_q[$];
    ev_t exp_q[$];
    int  rises[$];
    int  exp_pos;

    step_pulse_monitor #(
        .SCALE(SCALE), .TIMEOUT(TIMEOUT), .MIN_WIDTH(MIN_WIDTH), .FILTER_LEN(4)
    ) dut (
        .clock_in(clock_in), .resetn(resetn), .step_in(step_in), .dir_in(dir_in),
        .clear(clear), .position(position), .speed(speed), .speed_valid(speed_valid),
        .pulse_width(pulse_width), .stalled(stalled), .width_err(width_err)
    );

    always #5 clock_in = ~clock_in;
    always @(posedge clock_in) cyc <= cyc + 1;
    always @(negedge clock_in) if (speed_valid) ev_q.push_back('{cyc, speed});

    // A closed period yields a speed report unless the next rise lands before the report is due.
    function automatic void build_expected();
        exp_q.delete();
        for (int i = 1; i < rises.size(); i++) begin
            int per;
            bit aborted;
            per     = rises[i] - rises[i-1];
            aborted = (i + 1 < rises.size()) && (rises[i+1] - rises[i] <= LAT - 3);
            if (!aborted) exp_q.push_back('{rises[i] + LAT, 32'(SCALE / per)});
        end
    endfunction

    task automatic do_reset();
        resetn = 1'b0; step_in = 1'b0; dir_in = 1'b0; clear = 1'b0;
        repeat (3) @(negedge clock_in);
        resetn = 1'b1;
        repeat (3) @(negedge clock_in);
        ev_q.delete(); rises.delete(); exp_pos = 0;
    endtask

    // Must be entered on a negedge; period = w + g cycles.
    task automatic pulse(input int w, input int g, input logic d);
        dir_in = d; step_in = 1'b1;
        rises.push_back(cyc);
        exp_pos += d ? 1 : -1;
        repeat (w) @(negedge clock_in);
        step_in = 1'b0;
        repeat (g) @(negedge clock_in);
    endtask

    task automatic test_reset();
        do_reset();
        repeat (20) @(negedge clock_in);
        checks++; if (position !== 32'd0) begin errors++; $display("FAIL rst_position: got %0h expected 0", position); end
        checks++; if (speed !== 32'd0) begin errors++; $display("FAIL rst_speed: got %0d expected 0", speed); end
        checks++; if (stalled !== 1'b1) begin errors++; $display("FAIL rst_stalled: got %b expected 1", stalled); end
        checks++; if (width_err !== 1'b0) begin errors++; $display("FAIL rst_width_err: got %b expected 0", width_err); end
        checks++; if (pulse_width !== 28'd0) begin errors++; $display("FAIL rst_pulse_width: got %0d expected 0", pulse_width); end
        checks++; if (ev_q.size() != 0) begin errors++; $display("FAIL rst_no_valid: got %0d strobes expected 0", ev_q.size()); end
    endtask

    task automatic test_forward();
        do_reset();
        for (int i = 0; i < 5; i++) begin
            pulse(10, 90, 1'b1);
            if (i == 0) begin
                checks++; if (stalled !== 1'b1) begin errors++; $display("FAIL fwd_stalled_first: got %b expected 1", stalled); end
            end
        end
        repeat (40) @(negedge clock_in);
        build_expected();
        checks++; if (position !== 32'(exp_pos)) begin errors++; $display("FAIL fwd_position: got %0d expected %0d", position, exp_pos); end
        checks++; if (pulse_width !== 28'd10) begin errors++; $display("FAIL fwd_pulse_width: got %0d expected 10", pulse_width); end
        checks++; if (ev_q.size() != exp_q.size()) begin errors++; $display("FAIL fwd_valid_count: got %0d expected %0d", ev_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < ev_q.size(); i++) begin
            checks++;
            if (ev_q[i].c != exp_q[i].c || ev_q[i].v !== exp_q[i].v) begin
                errors++;
                $display("FAIL fwd_valid[%0d]: got cyc %0d speed %0d expected cyc %0d speed %0d", i, ev_q[i].c, ev_q[i].v, exp_q[i].c, exp_q[i].v);
            end
        end
        checks++; if (speed !== 32'd1000) begin errors++; $display("FAIL fwd_speed: got %0d expected 1000", speed); end
        checks++; if (stalled !== 1'b0) begin errors++; $display("FAIL fwd_stalled: got %b expected 0", stalled); end
    endtask

    task automatic test_reverse_clear();
        do_reset();
        for (int i = 0; i < 3; i++) pulse(5, 60, 1'b0);
        checks++; if (position !== 32'hFFFF_FFFD) begin errors++; $display("FAIL rev_position: got %0h expected fffffffd", position); end
        // clear lands in the cycle the rise is detected: the step must be dropped
        dir_in = 1'b1; step_in = 1'b1;
        repeat (2) @(negedge clock_in);
        clear = 1'b1;
        @(negedge clock_in);
        clear = 1'b0;
        repeat (3) @(negedge clock_in);
        step_in = 1'b0;
        repeat (30) @(negedge clock_in);
        checks++; if (position !== 32'd0) begin errors++; $display("FAIL clear_drop_step: got %0h expected 0", position); end
        pulse(5, 60, 1'b1);
        checks++; if (position !== 32'd1) begin errors++; $display("FAIL after_clear_step: got %0h expected 1", position); end
    endtask

    task automatic test_width_err();
        do_reset();
        pulse(1, 60, 1'b1);
        checks++; if (width_err !== 1'b1) begin errors++; $display("FAIL werr_set: got %b expected 1", width_err); end
        checks++; if (pulse_width !== 28'd1) begin errors++; $display("FAIL werr_width1: got %0d expected 1", pulse_width); end
        pulse(10, 60, 1'b1);
        checks++; if (width_err !== 1'b1) begin errors++; $display("FAIL werr_sticky: got %b expected 1", width_err); end
        checks++; if (pulse_width !== 28'd10) begin errors++; $display("FAIL werr_width10: got %0d expected 10", pulse_width); end
        clear = 1'b1; @(negedge clock_in); clear = 1'b0; @(negedge clock_in);
        checks++; if (width_err !== 1'b0) begin errors++; $display("FAIL werr_clear: got %b expected 0", width_err); end
        do_reset();
        pulse(MIN_WIDTH, 60, 1'b1);
        checks++; if (width_err !== 1'b0) begin errors++; $display("FAIL werr_min_width_ok: got %b expected 0", width_err); end
        checks++; if (pulse_width !== 28'(MIN_WIDTH)) begin errors++; $display("FAIL werr_min_width: got %0d expected %0d", pulse_width, MIN_WIDTH); end
    endtask

    task automatic test_timeout();
        int n_ev;
        do_reset();
        for (int i = 0; i < 3; i++) pulse(10, 90, 1'b1);
        repeat (40) @(negedge clock_in);
        checks++; if (speed !== 32'd1000) begin errors++; $display("FAIL to_pre_speed: got %0d expected 1000", speed); end
        n_ev = ev_q.size();
        repeat (TIMEOUT + 100) @(negedge clock_in);
        checks++; if (speed !== 32'd0) begin errors++; $display("FAIL to_speed: got %0d expected 0", speed); end
        checks++; if (stalled !== 1'b1) begin errors++; $display("FAIL to_stalled: got %b expected 1", stalled); end
        checks++; if (ev_q.size() != n_ev) begin errors++; $display("FAIL to_no_valid: got %0d strobes expected %0d", ev_q.size(), n_ev); end
        rises.delete();
        pulse(10, 40, 1'b1);
        pulse(10, 40, 1'b1);
        repeat (40) @(negedge clock_in);
        checks++; if (ev_q.size() != n_ev + 1) begin errors++; $display("FAIL to_resume_count: got %0d strobes expected %0d", ev_q.size(), n_ev + 1); end
        else begin
            checks++;
            if (ev_q[n_ev].c != rises[1] + LAT || ev_q[n_ev].v !== 32'd2000) begin
                errors++;
                $display("FAIL to_resume_valid: got cyc %0d speed %0d expected cyc %0d speed 2000", ev_q[n_ev].c, ev_q[n_ev].v, rises[1] + LAT);
            end
        end
        checks++; if (stalled !== 1'b0) begin errors++; $display("FAIL to_resume_stalled: got %b expected 0", stalled); end
    endtask

    task automatic test_reset_mid_divide();
        do_reset();
        pulse(10, 90, 1'b1);
        dir_in = 1'b1; step_in = 1'b1;
        repeat (10) @(negedge clock_in);
        step_in = 1'b0;
        repeat (3) @(negedge clock_in);
        resetn = 1'b0;
        #1;
        checks++; if (position !== 32'd0 || speed !== 32'd0 || speed_valid !== 1'b0 || pulse_width !== 28'd0 || stalled !== 1'b1 || width_err !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset_outputs: got pos %0h speed %0d sv %b pw %0d stall %b werr %b expected 0 0 0 0 1 0", position, speed, speed_valid, pulse_width, stalled, width_err);
        end
        repeat (2) @(negedge clock_in);
        resetn = 1'b1;
        repeat (60) @(negedge clock_in);
        checks++; if (ev_q.size() != 0) begin errors++; $display("FAIL mid_reset_no_valid: got %0d strobes expected 0", ev_q.size()); end
        checks++; if (stalled !== 1'b1 || speed !== 32'd0) begin errors++; $display("FAIL mid_reset_after: got stall %b speed %0d expected 1 0", stalled, speed); end
    endtask

    task automatic test_random();
        bit exp_werr;
        int last_w;
        for (int trial = 0; trial < 3; trial++) begin
            do_reset();
            exp_werr = 1'b0;
            last_w   = 0;
            for (int i = 0; i < 12; i++) begin
                int w, g;
                w = $urandom_range(8, 1);
                g = $urandom_range(80, 1);
                if (w < MIN_WIDTH) exp_werr = 1'b1;
                last_w = w;
                pulse(w, g, 1'($urandom_range(1, 0)));
            end
            repeat (45) @(negedge clock_in);
            build_expected();
            checks++; if (position !== 32'(exp_pos)) begin errors++; $display("FAIL rnd%0d_position: got %0d expected %0d", trial, $signed(position), exp_pos); end
            checks++; if (width_err !== exp_werr) begin errors++; $display("FAIL rnd%0d_width_err: got %b expected %b", trial, width_err, exp_werr); end
            checks++; if (pulse_width !== 28'(last_w)) begin errors++; $display("FAIL rnd%0d_pulse_width: got %0d expected %0d", trial, pulse_width, last_w); end
            checks++; if (ev_q.size() != exp_q.size()) begin errors++; $display("FAIL rnd%0d_valid_count: got %0d expected %0d", trial, ev_q.size(), exp_q.size()); end
            for (int i = 0; i < exp_q.size() && i < ev_q.size(); i++) begin
                checks++;
                if (ev_q[i].c != exp_q[i].c || ev_q[i].v !== exp_q[i].v) begin
                    errors++;
                    $display("FAIL rnd%0d_valid[%0d]: got cyc %0d speed %0d expected cyc %0d speed %0d", trial, i, ev_q[i].c, ev_q[i].v, exp_q[i].c, exp_q[i].v);
                end
            end
            checks++;
            if (stalled !== (exp_q.size() == 0)) begin errors++; $display("FAIL rnd%0d_stalled: got %b expected %b", trial, stalled, exp_q.size() == 0); end
            checks++;
            if (speed !== (exp_q.size() == 0 ? 32'd0 : exp_q[exp_q.size()-1].v)) begin
                errors++;
                $display("FAIL rnd%0d_speed: got %0d expected %0d", trial, speed, exp_q.size() == 0 ? 32'd0 : exp_q[exp_q.size()-1].v);
            end
        end
    endtask

    initial begin
        test_reset();
        test_forward();
        test_reverse_clear();
        test_width_err();
        test_timeout();
        test_reset_mid_divide();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
